// File: rtl/spi_slave_frame.sv
// spi_slave_frame
//   SPI slave that exchanges one fixed-length word per chip-select frame.
//   Mode: sclk idles high, the slave changes miso on sclk falling edges and
//   samples mosi on sclk rising edges, MSB first on both lines. All SPI
//   inputs are oversampled by clk (sclk must be at most clk/8).
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   sclk        SPI clock from master (idle high)
//   cs_bar      SPI chip select, active low
//   mosi        serial data in from master
//   miso        serial data out to master (forced 0 while not enabled)
//   miso_oe     miso drive enable (synchronized cs_bar inverted)
//   loopback    next frame transmits the last received word
//   tx_data     word to transmit
//   tx_load     strobe capturing tx_data into the holding register
//   tx_ready    holding register empty
//   rx_data     last complete received word
//   rx_valid    one-cycle pulse when rx_data updates
//   tx_underrun one-cycle pulse when a frame starts with nothing to send
//   frame_err   one-cycle pulse when cs_bar rises mid-frame
module spi_slave_frame #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_bar,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic                  loopback,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [SYNC_STAGES:0]   settle_q, settle_d;
  logic                   armed_q, armed_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   miso_q, miso_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_underrun_q, tx_underrun_d;
  logic                   frame_err_q, frame_err_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic consume, load_accept, last_bit;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  // A fall only counts once the synchronizer holds real data and cs_bar has
  // been seen high, so a cs_bar held low across reset cannot start a frame.
  assign cs_fall   = ~cs_s & cs_prev_q & armed_q;

  assign last_bit = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));

  // Input synchronizers plus the extra copy used for edge detection.
  // settle_q fills with ones after reset; its top bit marks when the
  // synchronized cs_bar reflects the pin rather than the reset value.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_bar};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    settle_d    = {settle_q[SYNC_STAGES-1:0], 1'b1};
    armed_d     = armed_q | (settle_q[SYNC_STAGES] & cs_s);
  end

  // FSM next state. cs_bar rising has priority over any sclk edge in SHIFT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT: begin
        if (cs_rise) state_d = IDLE;
        else if (sclk_rise && last_bit) state_d = DONE;
      end
      DONE:    if (cs_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and shift datapath.
  // The transmit register shifts only on falls after the first rising edge:
  // the leading fall of a frame (sclk idles high) must keep the MSB on miso.
  always_comb begin
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_err_d   = 1'b0;
    consume       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          if (loopback) begin
            tx_shift_d = rx_data_q;
          end else if (hold_full_q) begin
            tx_shift_d = hold_q;
            consume    = 1'b1;
          end else begin
            tx_shift_d    = '0;
            tx_underrun_d = 1'b1;
          end
          miso_d = tx_shift_d[DATA_WIDTH-1];
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          rx_shift_d  = '0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (last_bit) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall && (bit_cnt_q < CNT_W'(DATA_WIDTH))) begin
          if (bit_cnt_q != '0) tx_shift_d = tx_shift_q << 1;
          miso_d = tx_shift_d[DATA_WIDTH-1];
        end
      end
      default: ;
    endcase
  end

  // Holding register. A load arriving in the same cycle as a frame-start
  // consume is accepted: the frame takes the old word, the new one stays.
  always_comb begin
    load_accept = tx_load & (~hold_full_q | consume);
    hold_d      = load_accept ? tx_data : hold_q;
    hold_full_d = load_accept | (hold_full_q & ~consume);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath, synchronizer and holding-register flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q   <= '1;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b1;
      cs_prev_q     <= 1'b1;
      settle_q      <= '0;
      armed_q       <= 1'b0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      bit_cnt_q     <= '0;
      miso_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      cs_prev_q     <= cs_prev_d;
      settle_q      <= settle_d;
      armed_q       <= armed_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      miso_q        <= miso_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign miso_oe     = ~cs_s;
  assign miso        = miso_q & miso_oe;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_frame.sv
// tb_spi_slave_frame
//   Drives spi_slave_frame as an SPI master at clk/8. Expected receive words
//   are queued when a full frame is started and compared whenever rx_valid
//   pulses; miso is captured on each sclk rising edge and compared per frame.
module tb_spi_slave_frame;

  localparam int W    = 16;
  localparam int HALF = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sclk = 1'b1;
  logic         cs_bar = 1'b1;
  logic         mosi = 1'b0;
  logic         loopback = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_load = 1'b0;
  logic         miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_err;
  logic [W-1:0] rx_data;

  int checkCount = 0;
  int errorCount = 0;
  int rxValidCount = 0;
  int underrunCount = 0;
  int frameErrCount = 0;

  logic [W-1:0] rxQueue[$];

  always #5 clk = ~clk;

  spi_slave_frame #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .cs_bar      (cs_bar),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .loopback    (loopback),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .frame_err   (frame_err)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_miso"}, miso, 0);
    checkOutput({tag, "_miso_oe"}, miso_oe, 0);
    checkOutput({tag, "_rx_data"}, rx_data, 0);
    checkOutput({tag, "_rx_valid"}, rx_valid, 0);
    checkOutput({tag, "_tx_underrun"}, tx_underrun, 0);
    checkOutput({tag, "_frame_err"}, frame_err, 0);
    checkOutput({tag, "_tx_ready"}, tx_ready, 1);
  endtask

  task automatic loadTx(input logic [W-1:0] word);
    tx_data = word;
    tx_load = 1'b1;
    waitClk(1);
    tx_load = 1'b0;
  endtask

  // Pulse counting and scoreboard pop, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rxValidCount++;
      checkOutput("rx_expected_pending", rxQueue.size() != 0, 1);
      if (rxQueue.size() != 0) checkOutput("rx_data", rx_data, rxQueue.pop_front());
    end
    if (tx_underrun === 1'b1) underrunCount++;
    if (frame_err === 1'b1) frameErrCount++;
  end

  // One master frame of nBits sclk cycles. Bits past W send ones so any
  // extra shifting would corrupt the received word. resetAtEnd pulses reset
  // instead of finishing the frame normally.
  task automatic applyStimulus(input logic [W-1:0] mosiWord, input int nBits,
                               input bit resetAtEnd, input bit pushRx,
                               input bit checkMiso, input logic [W-1:0] misoWord);
    logic [W-1:0] seen;
    seen = '0;
    if (pushRx) rxQueue.push_back(mosiWord);
    cs_bar = 1'b0;
    waitClk(HALF);
    for (int i = 0; i < nBits; i++) begin
      sclk = 1'b0;
      mosi = (i < W) ? mosiWord[W-1-i] : 1'b1;
      waitClk(HALF);
      if (i < W) seen[W-1-i] = miso;
      if (i == 0) checkOutput("miso_oe_active", miso_oe, 1);
      sclk = 1'b1;
      waitClk(HALF);
    end
    if (resetAtEnd) begin
      reset = 1'b0;
      #1;
      checkResetValues("midframe_reset");
      cs_bar = 1'b1;
      sclk   = 1'b1;
      mosi   = 1'b0;
      waitClk(3);
      reset = 1'b1;
    end else begin
      cs_bar = 1'b1;
    end
    waitClk(10);
    if (checkMiso) checkOutput("miso_word", seen, misoWord);
    checkOutput("miso_oe_idle", miso_oe, 0);
    checkOutput("miso_idle", miso, 0);
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vBase, uBase, fBase;

    reset = 1'b0;
    waitClk(3);
    checkResetValues("reset");
    reset = 1'b1;
    waitClk(10);
    checkResetValues("after_release");

    // Loaded word goes out while 0x1234 comes in.
    $display("[TB] scenario: normal frame");
    loadTx(16'hA5C3);
    checkOutput("tx_ready_after_load", tx_ready, 0);
    vBase = rxValidCount; uBase = underrunCount;
    applyStimulus(16'h1234, 16, 1'b0, 1'b1, 1'b1, 16'hA5C3);
    checkOutput("s1_rx_valid_pulses", rxValidCount - vBase, 1);
    checkOutput("s1_underrun_pulses", underrunCount - uBase, 0);
    checkOutput("s1_tx_ready", tx_ready, 1);
    checkOutput("s1_rx_data", rx_data, 16'h1234);

    // Nothing loaded: zeros go out and underrun pulses once.
    $display("[TB] scenario: underrun");
    vBase = rxValidCount; uBase = underrunCount;
    applyStimulus(16'hFFFF, 16, 1'b0, 1'b1, 1'b1, 16'h0000);
    checkOutput("s2_underrun_pulses", underrunCount - uBase, 1);
    checkOutput("s2_rx_valid_pulses", rxValidCount - vBase, 1);

    // Loopback echoes the previously received 0xFFFF.
    $display("[TB] scenario: loopback");
    loopback = 1'b1;
    vBase = rxValidCount; uBase = underrunCount;
    applyStimulus(16'h0000, 16, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    loopback = 1'b0;
    checkOutput("s3_underrun_pulses", underrunCount - uBase, 0);
    checkOutput("s3_rx_valid_pulses", rxValidCount - vBase, 1);
    checkOutput("s3_rx_data", rx_data, 16'h0000);

    // Chip select raised after 9 bits, then a clean frame.
    $display("[TB] scenario: aborted frame");
    loadTx(16'h3C96);
    vBase = rxValidCount; fBase = frameErrCount;
    applyStimulus(16'hFFFF, 9, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("s4_frame_err_pulses", frameErrCount - fBase, 1);
    checkOutput("s4_rx_valid_pulses", rxValidCount - vBase, 0);
    checkOutput("s4_rx_data_kept", rx_data, 16'h0000);
    checkOutput("s4_tx_ready", tx_ready, 1);
    loadTx(16'h0F0F);
    vBase = rxValidCount; fBase = frameErrCount;
    applyStimulus(16'h5A5A, 16, 1'b0, 1'b1, 1'b1, 16'h0F0F);
    checkOutput("s4b_rx_valid_pulses", rxValidCount - vBase, 1);
    checkOutput("s4b_frame_err_pulses", frameErrCount - fBase, 0);
    checkOutput("s4b_rx_data", rx_data, 16'h5A5A);

    // Second load while full is ignored; 18 sclk cycles in one frame.
    $display("[TB] scenario: overlong frame");
    loadTx(16'h8001);
    loadTx(16'hFFFF);
    vBase = rxValidCount; fBase = frameErrCount;
    applyStimulus(16'hBEEF, 18, 1'b0, 1'b1, 1'b1, 16'h8001);
    checkOutput("s5_rx_valid_pulses", rxValidCount - vBase, 1);
    checkOutput("s5_frame_err_pulses", frameErrCount - fBase, 0);
    checkOutput("s5_rx_data", rx_data, 16'hBEEF);

    // Reset at bit 5 clears everything, including the loaded word.
    $display("[TB] scenario: reset mid-frame");
    loadTx(16'h1357);
    vBase = rxValidCount; fBase = frameErrCount; uBase = underrunCount;
    applyStimulus(16'h2468, 5, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("s6_rx_valid_pulses", rxValidCount - vBase, 0);
    checkOutput("s6_frame_err_pulses", frameErrCount - fBase, 0);
    checkOutput("s6_underrun_pulses", underrunCount - uBase, 0);
    checkOutput("s6_tx_ready", tx_ready, 1);
    checkOutput("s6_rx_data", rx_data, 16'h0000);
    loadTx(16'h7E81);
    vBase = rxValidCount;
    applyStimulus(16'hC3A5, 16, 1'b0, 1'b1, 1'b1, 16'h7E81);
    checkOutput("s6b_rx_valid_pulses", rxValidCount - vBase, 1);
    checkOutput("s6b_rx_data", rx_data, 16'hC3A5);

    checkOutput("rx_queue_drained", rxQueue.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/spi_slave_frame.md
SPI_SLAVE_FRAME -- requirements
Module: spi_slave_frame

Interface
Parameters:
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 16, as the SPI frame length in bits (supported range 8..32).
REQ-002 The block SHALL provide parameter SYNC_STAGES, default 2, as the synchronizer depth on sclk, cs_bar and mosi (minimum 2).

Ports:
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 sclk  input  1  SPI clock from the external master; idles high; must be at most clk/8.
REQ-006 cs_bar  input  1  chip select, active low.
REQ-007 mosi  input  1  serial data from the master, MSB first.
REQ-008 miso  output  1  serial data to the master, MSB first.
REQ-009 miso_oe  output  1  miso drive enable; high only while synchronized cs_bar is low.
REQ-010 loopback  input  1  when high, the next frame transmits the last received word instead of tx_data.
REQ-011 tx_data  input  DATA_WIDTH  word to transmit.
REQ-012 tx_load  input  1  one-cycle strobe; captures tx_data into the holding register.
REQ-013 tx_ready  output  1  high when the holding register is empty.
REQ-014 rx_data  output  DATA_WIDTH  last complete received word.
REQ-015 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-016 tx_underrun  output  1  one-cycle pulse when a frame starts with an empty holding register and loopback is low.
REQ-017 frame_err  output  1  one-cycle pulse when cs_bar deasserts mid-frame.

Function
REQ-018 sclk, cs_bar and mosi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected against one further registered copy.
REQ-019 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-020 IDLE -> SHIFT on a synchronized cs_bar falling edge. In that same cycle:
  - the shift register SHALL load rx_data if loopback is high;
  - otherwise it SHALL load the holding register if full, emptying it;
  - otherwise it SHALL load 0 and pulse tx_underrun;
  - miso SHALL present the loaded MSB;
  - the bit counter SHALL clear.
REQ-021 In SHIFT, on each synchronized sclk rising edge:
  - synchronized mosi SHALL shift into the receive register LSB;
  - the bit counter SHALL increment.
REQ-022 In SHIFT, on each synchronized sclk falling edge with bit counter below DATA_WIDTH, miso SHALL present the next transmit bit.
REQ-023 When the bit counter reaches DATA_WIDTH:
  - the FSM SHALL enter DONE;
  - rx_data SHALL load the receive register in the same cycle;
  - rx_valid SHALL pulse in that same cycle.
  Latency is 1 clk after the synchronized 16th rising edge.
REQ-024 In DONE, further sclk edges SHALL be ignored, miso SHALL hold its last value, and the FSM SHALL return to IDLE on synchronized cs_bar high.
REQ-025 If synchronized cs_bar rises while in SHIFT:
  - the FSM SHALL return to IDLE;
  - frame_err SHALL pulse;
  - rx_data and rx_valid SHALL be unaffected;
  - the partial word SHALL be discarded.
REQ-026 Holding-register loading:
  - tx_load with tx_ready high SHALL load tx_data and drop tx_ready the next cycle;
  - tx_load with tx_ready low SHALL be ignored.
REQ-027 If tx_load and the frame-start consume occur in the same cycle, the consume SHALL take the old contents and the new tx_data SHALL be captured; tx_ready stays low.
REQ-028 A cs_bar fall detected in the same cycle as a cs_bar rise handling SHALL be processed in the following cycle; no frame SHALL be lost for cs_bar high time of at least 2 clk after synchronization.
REQ-029 miso_oe SHALL equal the inverse of synchronized cs_bar; miso SHALL be 0 when miso_oe is low.

Reset
REQ-030 On reset low, asynchronously:
  - state = IDLE;
  - miso = 0, miso_oe = 0, rx_data = 0;
  - rx_valid = 0, tx_underrun = 0, frame_err = 0;
  - tx_ready = 1, holding and shift registers = 0;
  - synchronizer flops: sclk and cs_bar = 1, mosi = 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err pulse; after release, the block SHALL wait for a fresh cs_bar fall.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
  - Load tx_data = 0xA5C3, master sends 0x1234 at clk/8 -> miso shifts 0xA5C3 MSB first, rx_data = 0x1234, one rx_valid pulse, tx_ready = 1 after the frame starts.
  - No tx_load, loopback = 0, frame of 0xFFFF -> tx_underrun pulses once, miso shifts 0x0000, rx_data = 0xFFFF.
  - loopback = 1 after the previous frame, master sends 0x0000 -> miso shifts 0xFFFF, rx_data = 0x0000.
  - cs_bar raised after 9 bits -> frame_err pulses, no rx_valid, rx_data unchanged; the next full frame of 0x5A5A is received correctly.
  - 18 sclk rising edges in one frame -> exactly one rx_valid pulse, rx_data = first 16 bits.
  - Reset pulsed mid-frame at bit 5 -> all outputs at reset values, no pulses; the next frame is correct.
